// File: rtl/alarm_snooze_fsm.sv
// Alarm time store, match detection, ringing timeout and snooze re-arm for the 12-hour clock.
// Build option: define SNOOZE_LIMIT_EN to cap snoozes per alarm event at MAX_SNOOZES.
module alarm_snooze_fsm #(
  parameter int SNOOZE_MINUTES   = 9,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic       clk_en_pi,
  input  logic [5:0] seconds_pi,
  input  logic [5:0] minutes_pi,
  input  logic [3:0] hours_pi,
  input  logic       alarm_enable_pi,
  input  logic       set_mode_pi,
  input  logic       increment_minute_pi,
  input  logic       increment_hour_pi,
  input  logic       snooze_pi,
  input  logic       stop_pi,
  output logic [5:0] alarm_minutes_po,
  output logic [3:0] alarm_hours_po,
  output logic       ringing_po,
  output logic       snoozed_po,
  output logic [1:0] snooze_count_po
);

`ifdef SNOOZE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_RINGING, S_SNOOZE} state_t;

  state_t     state_q, state_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic [3:0] alarm_hr_q, alarm_hr_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [3:0] tgt_hr_q, tgt_hr_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] cnt_q, cnt_d;
  logic       match_q;
  logic       ringing_q, snoozed_q;

  logic       alarm_match, snooze_match, alarm_rise, snooze_rise;
  logic [6:0] snz_sum;
  logic [8:0] timer_inc;
  logic       timeout, snooze_ok;

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [3:0] inc_hr(input logic [3:0] h);
    return (h >= 4'd12) ? 4'd1 : h + 4'd1;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  assign alarm_match  = (hours_pi == alarm_hr_q) && (minutes_pi == alarm_min_q) && (seconds_pi == 6'd0);
  assign snooze_match = (hours_pi == tgt_hr_q) && (minutes_pi == tgt_min_q) && (seconds_pi == 6'd0);
  // Triggers are edge-qualified so a match held for a whole second fires once.
  assign alarm_rise   = alarm_match && !match_q;
  assign snooze_rise  = snooze_match && !match_q;

  assign snz_sum   = {1'b0, minutes_pi} + 7'(SNOOZE_MINUTES);
  assign timer_inc = {1'b0, timer_q} + 9'd1;
  assign timeout   = clk_en_pi && (timer_inc >= 9'(RING_TIMEOUT_SEC));
  assign snooze_ok = !LIMIT_EN || ({30'd0, cnt_q} < MAX_SNOOZES);

  always_comb begin
    state_d     = state_q;
    alarm_min_d = alarm_min_q;
    alarm_hr_d  = alarm_hr_q;
    tgt_min_d   = tgt_min_q;
    tgt_hr_d    = tgt_hr_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;

    if (set_mode_pi) begin
      if (increment_minute_pi) alarm_min_d = inc_min(alarm_min_q);
      if (increment_hour_pi)   alarm_hr_d  = inc_hr(alarm_hr_q);
    end

    if (!alarm_enable_pi) begin
      state_d = S_OFF;
      cnt_d   = 2'd0;
      timer_d = 8'd0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_ARMED;
        S_ARMED: begin
          if (alarm_rise) begin
            state_d = S_RINGING;
            timer_d = 8'd0;
            cnt_d   = 2'd0;
          end
        end
        S_RINGING: begin
          if (stop_pi) begin
            state_d = S_ARMED;
            timer_d = 8'd0;
          end else if (snooze_pi && snooze_ok) begin
            state_d = S_SNOOZE;
            timer_d = 8'd0;
            cnt_d   = sat_inc(cnt_q);
            if (snz_sum >= 7'd60) begin
              tgt_min_d = 6'(snz_sum - 7'd60);
              tgt_hr_d  = inc_hr(hours_pi);
            end else begin
              tgt_min_d = snz_sum[5:0];
              tgt_hr_d  = hours_pi;
            end
          end else if (timeout) begin
            state_d = S_ARMED;
            timer_d = 8'd0;
          end else if (clk_en_pi) begin
            timer_d = timer_inc[7:0];
          end
        end
        S_SNOOZE: begin
          if (stop_pi) begin
            state_d = S_ARMED;
          end else if (snooze_rise) begin
            state_d = S_RINGING;
            timer_d = 8'd0;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      state_q     <= S_OFF;
      alarm_min_q <= 6'd0;
      alarm_hr_q  <= 4'd12;
      tgt_min_q   <= 6'd0;
      tgt_hr_q    <= 4'd12;
      timer_q     <= 8'd0;
      cnt_q       <= 2'd0;
      match_q     <= 1'b0;
      ringing_q   <= 1'b0;
      snoozed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_min_q <= alarm_min_d;
      alarm_hr_q  <= alarm_hr_d;
      tgt_min_q   <= tgt_min_d;
      tgt_hr_q    <= tgt_hr_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      match_q     <= alarm_match || snooze_match;
      ringing_q   <= (state_d == S_RINGING);
      snoozed_q   <= (state_d == S_SNOOZE);
    end
  end

  assign alarm_minutes_po = alarm_min_q;
  assign alarm_hours_po   = alarm_hr_q;
  assign ringing_po       = ringing_q;
  assign snoozed_po       = snoozed_q;
  assign snooze_count_po  = cnt_q;

endmodule

// File: tb/tb_alarm_snooze_fsm.sv
// Bench for alarm_snooze_fsm: directed scenarios plus randomized traffic against a behavioural model.
module tb_alarm_snooze_fsm;
  localparam int SNOOZE_MINUTES   = 9;
  localparam int RING_TIMEOUT_SEC = 60;
  localparam int MAX_SNOOZES      = 3;

  localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic [5:0] sec = 6'd5, min = 6'd0;
  logic [3:0] hr = 4'd3;
  logic       en = 1'b0, set_mode = 1'b0, inc_m = 1'b0, inc_h = 1'b0;
  logic       snooze = 1'b0, stop = 1'b0;
  logic [5:0] a_min;
  logic [3:0] a_hr;
  logic       ringing, snoozed;
  logic [1:0] cnt;

  alarm_snooze_fsm #(
    .SNOOZE_MINUTES(SNOOZE_MINUTES),
    .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC),
    .MAX_SNOOZES(MAX_SNOOZES)
  ) dut (
    .clk_pi(clk),
    .rst_pi(rst),
    .clk_en_pi(clk_en),
    .seconds_pi(sec),
    .minutes_pi(min),
    .hours_pi(hr),
    .alarm_enable_pi(en),
    .set_mode_pi(set_mode),
    .increment_minute_pi(inc_m),
    .increment_hour_pi(inc_h),
    .snooze_pi(snooze),
    .stop_pi(stop),
    .alarm_minutes_po(a_min),
    .alarm_hours_po(a_hr),
    .ringing_po(ringing),
    .snoozed_po(snoozed),
    .snooze_count_po(cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time kept as plain integers, snooze target via minutes-of-half-day arithmetic.
  int mdl_mode = M_OFF;
  int mdl_ah = 12, mdl_am = 0, mdl_th = 12, mdl_tm = 0;
  int mdl_timer = 0, mdl_cnt = 0;
  bit mdl_prev = 0;

  task automatic model_step();
    bit am, sm, allowed;
    int tot;
    if (rst) begin
      mdl_mode = M_OFF; mdl_ah = 12; mdl_am = 0; mdl_th = 12; mdl_tm = 0;
      mdl_timer = 0; mdl_cnt = 0; mdl_prev = 0;
      return;
    end
    am = (int'(hr) == mdl_ah) && (int'(min) == mdl_am) && (sec == 0);
    sm = (int'(hr) == mdl_th) && (int'(min) == mdl_tm) && (sec == 0);
`ifdef SNOOZE_LIMIT_EN
    allowed = (mdl_cnt < MAX_SNOOZES);
`else
    allowed = 1'b1;
`endif
    if (!en) begin
      mdl_mode = M_OFF; mdl_cnt = 0; mdl_timer = 0;
    end else if (mdl_mode == M_OFF) begin
      mdl_mode = M_ARMED;
    end else if (mdl_mode == M_ARMED) begin
      if (am && !mdl_prev) begin mdl_mode = M_RING; mdl_timer = 0; mdl_cnt = 0; end
    end else if (mdl_mode == M_RING) begin
      if (stop) mdl_mode = M_ARMED;
      else if (snooze && allowed) begin
        tot = ((int'(hr) % 12) * 60 + int'(min) + SNOOZE_MINUTES) % 720;
        mdl_th = (tot / 60 == 0) ? 12 : tot / 60;
        mdl_tm = tot % 60;
        mdl_cnt = (mdl_cnt < 3) ? mdl_cnt + 1 : 3;
        mdl_timer = 0;
        mdl_mode = M_SNZ;
      end else if (clk_en) begin
        mdl_timer++;
        if (mdl_timer >= RING_TIMEOUT_SEC) mdl_mode = M_ARMED;
      end
    end else begin
      if (stop) mdl_mode = M_ARMED;
      else if (sm && !mdl_prev) begin mdl_mode = M_RING; mdl_timer = 0; end
    end
    if (set_mode) begin
      if (inc_m) mdl_am = (mdl_am + 1) % 60;
      if (inc_h) mdl_ah = mdl_ah % 12 + 1;
    end
    mdl_prev = am || sm;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_ringing", ringing, (mdl_mode == M_RING));
      chk("m_snoozed", snoozed, (mdl_mode == M_SNZ));
      chk("m_count", cnt, mdl_cnt);
      chk("m_alarm_hr", a_hr, mdl_ah);
      chk("m_alarm_min", a_min, mdl_am);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hr = 4'(h); min = 6'(m); sec = 6'(s);
  endtask

  task automatic pulse_h();
    inc_h = 1'b1; tick(); inc_h = 1'b0;
  endtask

  task automatic pulse_m();
    inc_m = 1'b1; tick(); inc_m = 1'b0;
  endtask

  task automatic random_phase(input int cycles, input int snz_div, input int stop_div);
    int r;
    for (int c = 0; c < cycles; c++) begin
      r = $urandom_range(0, 15);
      if (r < 3) set_time(mdl_ah, mdl_am, 0);
      else if (r < 5) set_time(mdl_th, mdl_tm, 0);
      else if (r >= 9) set_time($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 59));
      clk_en   = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 299) != 0);
      set_mode = ($urandom_range(0, 19) == 0);
      inc_m    = ($urandom_range(0, 3) == 0);
      inc_h    = ($urandom_range(0, 3) == 0);
      snooze   = ($urandom_range(0, snz_div - 1) == 0);
      stop     = ($urandom_range(0, stop_div - 1) == 0);
      tick();
    end
    clk_en = 0; set_mode = 0; inc_m = 0; inc_h = 0; snooze = 0; stop = 0; en = 1;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_alarm_hr", a_hr, 12);
    chk("rst_alarm_min", a_min, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozed", snoozed, 0);
    chk("rst_count", cnt, 0);

    en = 1; set_mode = 1;
    repeat (7) pulse_h();
    repeat (30) pulse_m();
    set_mode = 0; tick();
    chk("edit_hr_7", a_hr, 7);
    chk("edit_min_30", a_min, 30);

    set_time(7, 29, 59); tick(2);
    set_time(7, 30, 0); clk_en = 1; tick(); clk_en = 0;
    chk("ring_on_match", ringing, 1);
    tick(4);
    chk("ring_held", ringing, 1);
    stop = 1; tick(); stop = 0;
    chk("stop_to_armed", ringing, 0);
    tick(5);
    chk("no_retrigger", ringing, 0);
    set_time(7, 30, 1); clk_en = 1; tick(); clk_en = 0;

    set_mode = 1;
    repeat (5) pulse_h();
    repeat (25) pulse_m();
    set_mode = 0; tick();
    chk("edit_hr_12", a_hr, 12);
    chk("edit_min_55", a_min, 55);
    set_time(12, 54, 59); tick(2);
    set_time(12, 55, 0); tick();
    chk("ring_1255", ringing, 1);
    snooze = 1; tick(); snooze = 0;
    chk("snoozed", snoozed, 1);
    chk("snooze_cnt1", cnt, 1);
    set_time(1, 3, 59); tick(2);
    chk("no_ring_0103", ringing, 0);
    set_time(1, 4, 0); tick();
    chk("ring_0104", ringing, 1);
    chk("cnt_after_snooze_ring", cnt, 1);

    for (int i = 1; i <= RING_TIMEOUT_SEC; i++) begin
      set_time(1, 4 + i / 60, i % 60); clk_en = 1; tick(); clk_en = 0; tick();
      if (i == RING_TIMEOUT_SEC - 1) chk("before_timeout", ringing, 1);
    end
    chk("timeout_stop", ringing, 0);

    set_time(12, 54, 59); tick(2);
    set_time(12, 55, 0); tick();
    chk("new_event_cnt0", cnt, 0);
    snooze = 1; tick(); snooze = 0;
    chk("snoozed_again", snoozed, 1);
    en = 0; stop = 1; tick(); stop = 0;
    chk("disable_snoozed", snoozed, 0);
    chk("disable_cnt", cnt, 0);
    set_time(1, 3, 59); tick(2);
    set_time(1, 4, 0); tick(2);
    en = 1; tick(6);
    chk("reenable_no_ring", ringing, 0);

    set_mode = 1; inc_m = 1; inc_h = 1; tick(); inc_m = 0; inc_h = 0;
    chk("both_hr", a_hr, 1);
    chk("both_min", a_min, 56);
    repeat (4) pulse_m();
    set_mode = 0; tick();
    chk("min_wrap", a_min, 0);
    chk("min_no_carry", a_hr, 1);
    pulse_h(); tick();
    chk("edit_ignored", a_hr, 1);

    set_time(12, 59, 59); tick(2);
    set_time(1, 0, 0); tick();
    chk("ring_0100", ringing, 1);
    #2 rst = 1;
    #1 chk("async_rst_ring", ringing, 0);
    chk("async_rst_hr", a_hr, 12);
    @(negedge clk);
    rst = 0;
    tick();

    set_time(3, 0, 5); en = 1; tick(2);
    random_phase(4000, 40, 150);
    random_phase(4000, 400, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
